reg_file_param: RTL
===================

REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, register and datapath width.
REQ-002 The block SHALL provide parameter ADDR_W, default 2, register address width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL provide parameter BYPASS, default 1, which enables RAM-writeback read forwarding.
REQ-004 The block SHALL have the port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst, input, width 1, synchronous active-high reset.
REQ-006 The block SHALL have the ports rd_addr1 and rd_addr2, input, width ADDR_W, read addresses.
REQ-007 The block SHALL have the ports rd_data1 and rd_data2, output, width DATA_W, combinational read data.
REQ-008 The block SHALL have the port wr_addr, input, width ADDR_W, destination register (also the OUT source register).
REQ-009 The block SHALL have the port src_addr, input, width ADDR_W, MOV source register.
REQ-010 The block SHALL have the port op, input, width 3, operation code: NOP, ALU, IMM, MOV, OUT, IN, LDRAM.
REQ-011 The block SHALL have the ports imm_data, alu_data, ram_data and in_data, input, width DATA_W, write sources.
REQ-012 The block SHALL have the ports in_valid, input, width 1, and in_ready, output, width 1, input-terminal handshake.
REQ-013 The block SHALL have the ports out_data, output, width DATA_W, out_valid, output, width 1, and out_ready, input, width 1, output-terminal handshake.
REQ-014 The block SHALL have the port stall, output, width 1; while it is high the controller holds op and all addresses/data.
REQ-015 The block SHALL have the port dbg_regs, output, width NUM_REGS*DATA_W, all registers flattened, reg 0 in the LSBs.

Function
REQ-016 ALU, IMM and MOV SHALL write alu_data, imm_data or reg[src_addr] (pre-edge value) to reg[wr_addr] at the edge ending the cycle (1-cycle latency).
REQ-017 LDRAM SHALL capture wr_addr into a pending slot; on the following cycle ram_data SHALL be written to that register at the edge ending that cycle.
REQ-018 When a pending RAM writeback and a current-cycle write target the same register, the current-cycle write SHALL win.
REQ-019 With BYPASS=1, a read whose address equals the pending slot address SHALL return ram_data; with BYPASS=0 it SHALL return the stored value.
REQ-020 Back-to-back LDRAM operations SHALL be accepted every cycle, with no stall.
REQ-021 IN SHALL drive in_ready=1; with in_valid=1, in_data SHALL be written to reg[wr_addr]; with in_valid=0, stall=1 and no write occurs.
REQ-022 OUT SHALL load reg[wr_addr] into out_data and set out_valid when out_valid=0 or out_ready=1 in that cycle; otherwise stall=1.
REQ-023 out_valid SHALL clear when out_ready=1 and no OUT load occurs in that cycle; out_data SHALL hold while out_valid=1 and out_ready=0.
REQ-024 in_ready SHALL be 0 for any op other than IN; stall SHALL be 0 for any op other than IN or OUT.
REQ-025 Out-of-range op codes SHALL behave as NOP.

Reset
REQ-026 With rst high at an edge, all registers, out_data, out_valid and the pending slot SHALL become 0, overriding any op in that cycle.
REQ-027 A reset asserted while a RAM writeback is pending SHALL discard that writeback.
REQ-028 During reset, stall and in_ready SHALL still follow op combinationally; no state SHALL change.

Structure
REQ-029 The op encodings SHALL live in the shared package reg_file_pkg, as constants OP_NOP=0, OP_ALU=1, OP_IMM=2, OP_MOV=3, OP_OUT=4, OP_IN=5 and OP_LDRAM=6.
REQ-030 The output handshake register SHALL be the sub-module term_out_buf, parameterised by DATA_W.

Verification
REQ-031 Bench scenario: rst, then IMM r2=0x5A, then MOV r3<-r2 -> dbg_regs byte3=0x5A two cycles after the IMM.
REQ-032 Bench scenario: LDRAM r1 with ram_data=0xC3 in the next cycle and rd_addr1=1 -> rd_data1=0xC3 in that cycle (BYPASS=1); reg1=0xC3 after the edge.
REQ-033 Bench scenario: LDRAM r1 followed by ALU r1 with alu_data=0x11 in the next cycle -> reg1=0x11.
REQ-034 Bench scenario: OUT r0=0x07 with out_ready=0, then a second OUT -> stall=1 and out_data=0x07 held; out_ready=1 -> second value loaded with no bubble.
REQ-035 Bench scenario: IN with in_valid=0 for 3 cycles, then 1 with in_data=0xEE -> stall high for 3 cycles, then reg[wr_addr]=0xEE.
REQ-036 Bench scenario: rst during a pending LDRAM, with DATA_W=16 and ADDR_W=3 -> all registers 0 and no writeback next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared definitions for the parameterised register file: operation encodings.
package reg_file_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_ALU   = 3'd1,
      OP_IMM   = 3'd2,
      OP_MOV   = 3'd3,
      OP_OUT   = 3'd4,
      OP_IN    = 3'd5,
      OP_LDRAM = 3'd6
   } op_e;

endpackage

// File: rtl/term_out_buf.sv
// Output-terminal holding register: one data word with a valid/ready handshake.
module term_out_buf #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   output logic              can_load_o
);

   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   // A new word may enter when the slot is empty or is being drained this cycle.
   assign can_load_o = !valid_q || ready_i;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/reg_file_param.sv
// Register file with immediate/ALU/move writes, delayed RAM writeback and in/out terminals.
module reg_file_param
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 2,
   parameter int BYPASS   = 1,
   parameter int NUM_REGS = 2**ADDR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_W-1:0]            rd_addr1,
   input  logic [ADDR_W-1:0]            rd_addr2,
   output logic [DATA_W-1:0]            rd_data1,
   output logic [DATA_W-1:0]            rd_data2,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [ADDR_W-1:0]            src_addr,
   input  logic [2:0]                   op,
   input  logic [DATA_W-1:0]            imm_data,
   input  logic [DATA_W-1:0]            alu_data,
   input  logic [DATA_W-1:0]            ram_data,
   input  logic [DATA_W-1:0]            in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         stall,
   output logic [NUM_REGS*DATA_W-1:0]   dbg_regs
);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              out_load;
   logic              out_can_load;

   always_comb begin
      wr_en    = 1'b0;
      wr_data  = '0;
      out_load = 1'b0;
      in_ready = 1'b0;
      stall    = 1'b0;
      case (op)
         OP_ALU: begin
            wr_en   = 1'b1;
            wr_data = alu_data;
         end
         OP_IMM: begin
            wr_en   = 1'b1;
            wr_data = imm_data;
         end
         OP_MOV: begin
            wr_en   = 1'b1;
            wr_data = regs_q[src_addr];
         end
         OP_OUT: begin
            out_load = out_can_load;
            stall    = !out_can_load;
         end
         OP_IN: begin
            in_ready = 1'b1;
            wr_en    = in_valid;
            wr_data  = in_data;
            stall    = !in_valid;
         end
         default: ;
      endcase
   end

   // The RAM writeback lands first so a same-cycle register write overrides it.
   always_comb begin
      regs_d = regs_q;
      if (pend_valid_q) regs_d[pend_addr_q] = ram_data;
      if (wr_en) regs_d[wr_addr] = wr_data;
      pend_valid_d = (op == OP_LDRAM);
      pend_addr_d  = wr_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
      end else begin
         regs_q       <= regs_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
      end
   end

   assign rd_data1 = (BYPASS != 0 && pend_valid_q && rd_addr1 == pend_addr_q) ? ram_data : regs_q[rd_addr1];
   assign rd_data2 = (BYPASS != 0 && pend_valid_q && rd_addr2 == pend_addr_q) ? ram_data : regs_q[rd_addr2];

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_dbg
      assign dbg_regs[g*DATA_W +: DATA_W] = regs_q[g];
   end

   term_out_buf #(
      .DATA_W (DATA_W)
   ) u_out_buf (
      .clk        (clk),
      .rst        (rst),
      .load_i     (out_load),
      .data_i     (regs_q[wr_addr]),
      .ready_i    (out_ready),
      .data_o     (out_data),
      .valid_o    (out_valid),
      .can_load_o (out_can_load)
   );

endmodule
